// File: rtl/visualizer_pkg.sv
// Shared types and constants for the audio bar visualizer (writer and VGA sides).
package visualizer_pkg;

  typedef enum logic [2:0] {
    ST_COLLECT   = 3'd0,
    ST_CAPTURE   = 3'd1,
    ST_WRITE     = 3'd2,
    ST_PUBLISH   = 3'd3,
    ST_WAIT_DONE = 3'd4
  } bw_state_t;

  localparam int LEFT_MSB = 31;
  localparam int LEFT_LSB = 16;

  localparam int NUM_BARS_DEF = 20;
  localparam int HEIGHT_W_DEF = 6;

endpackage

// File: rtl/peak_detector.sv
// Running maximum of saturated absolute sample values; cleared once per bar.
module peak_detector (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_clear,
  input  logic        i_valid,
  input  logic [15:0] i_sample,
  output logic [14:0] o_peak
);

  logic [14:0] w_mag;
  logic [14:0] r_peak;

  // -32768 has no 15-bit magnitude, so it is pinned to full scale.
  always_comb begin
    w_mag = i_sample[14:0];
    if (i_sample[15]) begin
      if (i_sample[14:0] == 15'd0) w_mag = 15'h7FFF;
      else                         w_mag = 15'(~i_sample[14:0]) + 15'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)                           r_peak <= '0;
    else if (i_clear)                    r_peak <= '0;
    else if (i_valid && (w_mag > r_peak)) r_peak <= w_mag;
  end

  assign o_peak = r_peak;

endmodule

// File: rtl/bar_ram_writer.sv
// Drains audio samples from the FIFO, reduces them to per-bar peak heights,
// writes a frame into the bar RAM and hands it to the VGA reader.
module bar_ram_writer
  import visualizer_pkg::*;
#(
  parameter int NUM_BARS        = NUM_BARS_DEF,
  parameter int SAMPLES_PER_BAR = 32,
  parameter int HEIGHT_W        = HEIGHT_W_DEF,
  parameter int ADDR_W          = 6,
  parameter int TIMEOUT         = 4096
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic [31:0]         fifo_q,
  input  logic                fifo_rdempty,
  output logic                fifo_rdreq,
  output logic [ADDR_W-1:0]   ram_wraddress,
  output logic [HEIGHT_W-1:0] ram_data,
  output logic                ram_wren,
  output logic                data_back,
  input  logic                control_bit,
  output logic                frame_done,
  output logic [2:0]          o_dbg_state
);

  localparam int CNT_W = $clog2(SAMPLES_PER_BAR + 1);
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(SAMPLES_PER_BAR - 1);
  localparam logic [ADDR_W-1:0] LAST_BAR = ADDR_W'(NUM_BARS - 1);
  localparam logic [TMR_W-1:0]  LAST_TMR = TMR_W'(TIMEOUT - 1);

  bw_state_t         r_state, w_next;
  logic [CNT_W-1:0]  r_count;
  logic [ADDR_W-1:0] r_bar;
  logic [TMR_W-1:0]  r_timer;
  logic              r_skip;
  logic              r_frame_done;
  logic              w_can_read, w_rdreq, w_capture, w_clear, w_frame_done;
  logic [14:0]       w_peak;
  logic              w_unused_right;

  assign w_unused_right = ^fifo_q[LEFT_LSB-1:0];

  peak_detector u_peak (
    .i_clk    (CLOCK_50),
    .i_rst    (reset),
    .i_clear  (w_clear),
    .i_valid  (w_capture),
    .i_sample (fifo_q[LEFT_MSB:LEFT_LSB]),
    .o_peak   (w_peak)
  );

  // Handshake: fifo_rdreq is a one-cycle pop, never issued while fifo_rdempty
  // is high nor on the cycle after a pop; data is taken the following cycle.
  // data_back stays high from the cycle after the last write until the reader
  // has shown control_bit low then high (or the publish times out).
  always_comb begin
    w_next        = r_state;
    w_rdreq       = 1'b0;
    w_capture     = 1'b0;
    w_clear       = 1'b0;
    w_frame_done  = 1'b0;
    ram_wren      = 1'b0;
    ram_wraddress = '0;
    ram_data      = '0;
    data_back     = 1'b0;
    w_can_read    = !fifo_rdempty && !r_skip && !reset;
    case (r_state)
      ST_COLLECT: begin
        if (w_can_read) begin
          w_rdreq = 1'b1;
          w_next  = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        w_capture = 1'b1;
        w_next    = (r_count == LAST_CNT) ? ST_WRITE : ST_COLLECT;
      end
      ST_WRITE: begin
        ram_wren      = 1'b1;
        ram_wraddress = r_bar;
        ram_data      = w_peak[14 -: HEIGHT_W];
        w_clear       = 1'b1;
        w_next        = (r_bar == LAST_BAR) ? ST_PUBLISH : ST_COLLECT;
      end
      ST_PUBLISH: begin
        data_back = 1'b1;
        w_rdreq   = w_can_read;
        if (!control_bit)             w_next = ST_WAIT_DONE;
        else if (r_timer == LAST_TMR) w_next = ST_COLLECT;
      end
      ST_WAIT_DONE: begin
        data_back = 1'b1;
        w_rdreq   = w_can_read;
        if (control_bit) begin
          w_next       = ST_COLLECT;
          w_frame_done = 1'b1;
        end
      end
      default: w_next = ST_COLLECT;
    endcase
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      r_state      <= ST_COLLECT;
      r_count      <= '0;
      r_bar        <= '0;
      r_timer      <= '0;
      r_skip       <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_skip       <= w_rdreq;
      r_frame_done <= w_frame_done;
      if (w_capture)    r_count <= r_count + 1'b1;
      else if (w_clear) r_count <= '0;
      if (r_state == ST_WRITE) r_bar <= (r_bar == LAST_BAR) ? '0 : r_bar + 1'b1;
      r_timer <= (r_state == ST_PUBLISH && w_next == ST_PUBLISH) ? r_timer + 1'b1 : '0;
    end
  end

  assign fifo_rdreq  = w_rdreq;
  assign frame_done  = r_frame_done;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bar_ram_writer.sv
// Directed and randomized bench for bar_ram_writer with a FIFO model and a
// transaction-level scoreboard of expected RAM writes.
module tb_bar_ram_writer;
  import visualizer_pkg::*;

  localparam int NB  = 2;
  localparam int SPB = 4;
  localparam int HW  = 6;
  localparam int AW  = 6;
  localparam int TO  = 64;

  logic          clk          = 1'b0;
  logic          rst          = 1'b0;
  logic [31:0]   fifo_q       = '0;
  logic          fifo_rdempty = 1'b1;
  logic          control_bit  = 1'b1;
  logic          fifo_rdreq, ram_wren, data_back, frame_done;
  logic [AW-1:0] ram_wraddress;
  logic [HW-1:0] ram_data;
  logic [2:0]    dbg_state;

  logic [31:0]      fifo_mem[$];
  logic             hold_empty = 1'b0;
  logic [AW+HW-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;
  int pend_peak = 0, pend_cnt = 0, model_addr = 0;
  logic obs_db, obs_fd, obs_wren, obs_rdreq;
  logic [2:0] obs_state;

  bar_ram_writer #(
    .NUM_BARS(NB), .SAMPLES_PER_BAR(SPB), .HEIGHT_W(HW), .ADDR_W(AW), .TIMEOUT(TO)
  ) dut (
    .CLOCK_50      (clk),
    .reset         (rst),
    .fifo_q        (fifo_q),
    .fifo_rdempty  (fifo_rdempty),
    .fifo_rdreq    (fifo_rdreq),
    .ram_wraddress (ram_wraddress),
    .ram_data      (ram_data),
    .ram_wren      (ram_wren),
    .data_back     (data_back),
    .control_bit   (control_bit),
    .frame_done    (frame_done),
    .o_dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // driver tasks
  task automatic update_empty();
    fifo_rdempty = hold_empty || (fifo_mem.size() == 0);
  endtask

  // Reference model: each group of SPB left samples becomes one write of the
  // saturated peak magnitude scaled down to HW bits, at consecutive addresses.
  task automatic push_sample(input logic [15:0] s);
    int v, m;
    fifo_mem.push_back({s, 16'($urandom)});
    update_empty();
    v = int'($signed(s));
    m = (v < 0) ? -v : v;
    if (m > 32767) m = 32767;
    if (m > pend_peak) pend_peak = m;
    pend_cnt++;
    if (pend_cnt == SPB) begin
      exp_q.push_back({AW'(model_addr), HW'(pend_peak >> (15 - HW))});
      model_addr = (model_addr + 1) % NB;
      pend_peak  = 0;
      pend_cnt   = 0;
    end
  endtask

  task automatic push_list(input logic [15:0] v [8]);
    for (int i = 0; i < 8; i++) push_sample(v[i]);
  endtask

  task automatic push_junk();
    fifo_mem.push_back($urandom);
    update_empty();
  endtask

  task automatic model_reset();
    exp_q.delete();
    fifo_mem.delete();
    pend_peak  = 0;
    pend_cnt   = 0;
    model_addr = 0;
    update_empty();
  endtask

  // One clock: observe mid-cycle, then apply the FIFO pop after the edge.
  task automatic tick();
    logic rd, emp;
    @(negedge clk);
    obs_db    = data_back;
    obs_fd    = frame_done;
    obs_wren  = ram_wren;
    obs_rdreq = fifo_rdreq;
    obs_state = dbg_state;
    if (ram_wren) begin
      if (exp_q.size() == 0) check("unexpected_write", 32'(ram_wren), 32'd0);
      else check("ram_write", 32'({ram_wraddress, ram_data}), 32'(exp_q.pop_front()));
    end
    rd  = fifo_rdreq;
    emp = fifo_rdempty;
    if (rd && emp) check("rdreq_when_empty", 32'(rd), 32'd0);
    @(posedge clk);
    #1;
    if (rd && fifo_mem.size() != 0) fifo_q = fifo_mem.pop_front();
    update_empty();
  endtask

  task automatic wait_db(input int limit, input bit stall, output int idx);
    idx = -1;
    for (int i = 0; i < limit; i++) begin
      if (stall) begin
        hold_empty = ($urandom_range(0, 3) == 0);
        update_empty();
      end
      tick();
      if (obs_db) begin
        idx = i;
        break;
      end
    end
    hold_empty = 1'b0;
    update_empty();
    if (idx < 0) check("data_back_rise", 32'(obs_db), 32'd1);
  endtask

  task automatic handshake(input int pre, input int low);
    int db_low, wr, fd;
    db_low = 0; wr = 0; fd = 0;
    for (int i = 0; i < pre + low; i++) begin
      if (i == pre) control_bit = 1'b0;
      tick();
      if (!obs_db)  db_low++;
      if (obs_wren) wr++;
      if (obs_fd)   fd++;
    end
    control_bit = 1'b1;
    tick();
    check("db_last_high", 32'(obs_db), 32'd1);
    check("fd_not_early", 32'(obs_fd), 32'd0);
    tick();
    check("db_fall", 32'(obs_db), 32'd0);
    check("frame_done_pulse", 32'(obs_fd), 32'd1);
    tick();
    check("frame_done_single", 32'(obs_fd), 32'd0);
    check("db_held_in_window", 32'(db_low), 32'd0);
    check("no_wren_in_window", 32'(wr), 32'd0);
    check("no_fd_in_window", 32'(fd), 32'd0);
  endtask

  task automatic frame(input bit stall, input int pre, input int low, input int junk);
    int idx;
    wait_db(400, stall, idx);
    check("frame_writes_done", 32'(exp_q.size()), 32'd0);
    for (int j = 0; j < junk; j++) push_junk();
    handshake(pre, low);
    if (junk > 0) check("junk_drained", 32'(fifo_mem.size()), 32'd0);
  endtask

  initial begin
    logic [15:0] v [8];
    int idx, hi, fd, rq, wr, pre, low;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_rdreq", 32'(fifo_rdreq), 32'd0);
    check("rst_wren", 32'(ram_wren), 32'd0);
    check("rst_addr", 32'(ram_wraddress), 32'd0);
    check("rst_data", 32'(ram_data), 32'd0);
    check("rst_data_back", 32'(data_back), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_COLLECT));

    // single frame: heights 3 and 0, unstalled latency, 10/23 handshake with drain
    v = '{16'd100, 16'hF830, 16'd512, 16'd30, 16'd0, 16'd0, 16'd0, 16'd0};
    push_list(v);
    rst = 1'b0;
    wait_db(200, 1'b0, idx);
    check("frame_latency", 32'(idx), 32'(NB * (2 * SPB + 1)));
    check("frame_writes_done", 32'(exp_q.size()), 32'd0);
    repeat (5) push_junk();
    handshake(10, 23);
    check("junk_drained", 32'(fifo_mem.size()), 32'd0);

    // saturation and scaling boundaries
    v = '{16'h8000, 16'd0, 16'd0, 16'd0, 16'h7FFF, 16'd0, 16'd0, 16'd0};
    push_list(v);
    frame(1'b0, 3, 5, 0);
    v = '{16'h01FF, 16'd0, 16'h01FF, 16'd0, 16'h0200, 16'd0, 16'hFE01, 16'd0};
    push_list(v);
    frame(1'b0, 0, 1, 0);

    // publish timeout, then next frame restarts at address 0
    for (int i = 0; i < 8; i++) v[i] = 16'($urandom);
    push_list(v);
    wait_db(400, 1'b0, idx);
    check("frame_writes_done", 32'(exp_q.size()), 32'd0);
    hi = 1; fd = 0;
    for (int i = 0; i < TO + 4; i++) begin
      tick();
      if (obs_db) hi++;
      if (obs_fd) fd++;
    end
    check("timeout_db_cycles", 32'(hi), 32'(TO));
    check("timeout_no_frame_done", 32'(fd), 32'd0);
    v = '{16'd1500, 16'd40, 16'd2, 16'd3, 16'hC000, 16'd9, 16'd8, 16'd7};
    push_list(v);
    frame(1'b0, 2, 4, 0);

    // empty FIFO mid-bar: no reads, no writes, count held
    push_sample(16'd1024);
    push_sample(16'd1024);
    repeat (6) tick();
    hold_empty = 1'b1;
    update_empty();
    push_sample(16'd1024);
    push_sample(16'd1024);
    repeat (4) push_sample(16'd20000);
    rq = 0; wr = 0;
    repeat (20) begin
      tick();
      if (obs_rdreq) rq++;
      if (obs_wren)  wr++;
    end
    check("stall_rdreq", 32'(rq), 32'd0);
    check("stall_wren", 32'(wr), 32'd0);
    check("stall_state", 32'(obs_state), 32'(ST_COLLECT));
    hold_empty = 1'b0;
    update_empty();
    frame(1'b0, 2, 2, 0);

    // randomized frames with FIFO stalls and handshake delays
    for (int f = 0; f < 4; f++) begin
      for (int i = 0; i < 8; i++) begin
        case ($urandom_range(0, 5))
          0:       v[i] = 16'h8000;
          1:       v[i] = 16'h7FFF;
          2:       v[i] = 16'($urandom_range(0, 1023));
          default: v[i] = 16'($urandom);
        endcase
      end
      push_list(v);
      pre = $urandom_range(0, 30);
      low = $urandom_range(1, 25);
      frame(1'b1, pre, low, (pre + low >= 12) ? 4 : 0);
    end

    // reset during publish with FIFO non-empty
    for (int i = 0; i < 8; i++) v[i] = 16'($urandom);
    push_list(v);
    wait_db(400, 1'b0, idx);
    check("frame_writes_done", 32'(exp_q.size()), 32'd0);
    repeat (3) push_junk();
    rst = 1'b1;
    #1;
    check("rst_pub_rdreq", 32'(fifo_rdreq), 32'd0);
    check("rst_pub_data_back", 32'(data_back), 32'd0);
    check("rst_pub_wren", 32'(ram_wren), 32'd0);
    check("rst_pub_frame_done", 32'(frame_done), 32'd0);
    check("rst_pub_addr", 32'(ram_wraddress), 32'd0);
    check("rst_pub_data", 32'(ram_data), 32'd0);
    check("rst_pub_state", 32'(dbg_state), 32'(ST_COLLECT));
    model_reset();
    tick();
    tick();
    rst = 1'b0;

    // reset mid-bar discards the partial peak and count
    push_sample(16'd30000);
    push_sample(16'd30000);
    repeat (5) tick();
    rst = 1'b1;
    #1;
    check("rst_bar_wren", 32'(ram_wren), 32'd0);
    model_reset();
    tick();
    rst = 1'b0;
    v = '{16'd700, 16'd0, 16'd0, 16'd0, 16'd1500, 16'd0, 16'd0, 16'd0};
    push_list(v);
    frame(1'b0, 1, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
